// File: rtl/btb_update_arbiter.sv
// btb_update_arbiter
//   Owns the single BTB write port. EX branch-resolution updates are queued in
//   a DEPTH-entry FIFO and drained to the port one per accepted write. A
//   flush request (fence.i / context change) discards the queue and runs a
//   sweep that writes valid=0 to every entry. Predictions must be suppressed
//   while flush_busy_o is high.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   upd_valid_i/upd_ready_o    update handshake; upd_pc_i, upd_target_i, upd_taken_i
//   flush_req_i                one-cycle sweep request
//   flush_busy_o, flush_done_o sweep in progress / one-cycle completion pulse
//   btb_wr_*                   BTB write port (en/rdy handshake, idx, valid, tag, target)
//   fifo_cnt_o                 update FIFO occupancy
module btb_update_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int INDEX_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     upd_valid_i,
  input  logic [ADDR_W-1:0]        upd_pc_i,
  input  logic [ADDR_W-1:0]        upd_target_i,
  input  logic                     upd_taken_i,
  output logic                     upd_ready_o,
  input  logic                     flush_req_i,
  output logic                     flush_busy_o,
  output logic                     flush_done_o,
  output logic                     btb_wr_en_o,
  input  logic                     btb_wr_rdy_i,
  output logic [INDEX_W-1:0]       btb_wr_idx_o,
  output logic                     btb_wr_valid_o,
  output logic [ADDR_W-1:0]        btb_wr_tag_o,
  output logic [ADDR_W-1:0]        btb_wr_target_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, SWEEP} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              taken;
  } upd_t;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] sweep_q, sweep_d;
  logic               done_q,  done_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  upd_t               fifo_q [DEPTH];

  logic clear, push, pop, empty, full;
  upd_t head;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign head  = fifo_q[rd_ptr_q];

  // No pass-through: a full FIFO refuses even when the head pops this cycle.
  assign upd_ready_o  = !full && (state_q == IDLE);
  assign flush_busy_o = (state_q == SWEEP);
  assign flush_done_o = done_q;
  assign fifo_cnt_o   = cnt_q;

  assign push = upd_valid_i && upd_ready_o;
  assign pop  = (state_q == IDLE) && !empty && btb_wr_rdy_i;

  // Sweep control. A flush in either state restarts from entry 0 and drops
  // the queue, so a handshaked update in the flush cycle is lost on purpose.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d = SWEEP;
          sweep_d = '0;
          clear   = 1'b1;
        end
      end
      SWEEP: begin
        if (flush_req_i) begin
          sweep_d = '0;
          clear   = 1'b1;
        end else if (btb_wr_rdy_i) begin
          if (sweep_q == '1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Write port mux: sweep invalidates, otherwise the FIFO head.
  always_comb begin
    btb_wr_en_o     = 1'b0;
    btb_wr_idx_o    = '0;
    btb_wr_valid_o  = 1'b0;
    btb_wr_tag_o    = '0;
    btb_wr_target_o = '0;
    if (state_q == SWEEP) begin
      btb_wr_en_o  = 1'b1;
      btb_wr_idx_o = sweep_q;
    end else if (!empty) begin
      btb_wr_en_o     = 1'b1;
      btb_wr_idx_o    = head.pc[INDEX_W+1:2];
      btb_wr_valid_o  = head.taken;
      btb_wr_tag_o    = head.pc;
      btb_wr_target_o = head.taken ? head.target : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sweep_q  <= '0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: upd_pc_i, target: upd_target_i, taken: upd_taken_i};
  end

endmodule
